// File: rtl/seg_scan_driver_if.sv
// Bus between datapath registers and the multiplexed seven-segment driver.
// The master side supplies the value to display; the slave side drives the display pins.
interface seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] din;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    load;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_start;

  modport master (
    output din, dp_in, blank, load,
    input  seg, dp, an, frame_start
  );

  modport slave (
    input  din, dp_in, blank, load,
    output seg, dp, an, frame_start
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver with frame-synchronous update, dead time,
// leading-zero suppression and selectable output polarity.
module seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 2,
  parameter int ACTIVE_LOW  = 1,
  parameter int LZ_SUPPRESS = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  seg_scan_driver_if.slave bus
);
  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic          INV      = (ACTIVE_LOW != 0);

  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [DW-1:0]         r_shd_val;
  logic [NUM_DIGITS-1:0] r_shd_dp;
  logic [NUM_DIGITS-1:0] r_shd_blank;
  logic [DW-1:0]         r_disp_val;
  logic [NUM_DIGITS-1:0] r_disp_dp;
  logic [NUM_DIGITS-1:0] r_disp_blank;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_frame_start;

  logic                  w_commit;
  logic [DW-1:0]         w_val;
  logic [NUM_DIGITS-1:0] w_dpv;
  logic [NUM_DIGITS-1:0] w_blk;
  logic [DW-1:0]         w_upper;
  logic [3:0]            w_digit;
  logic                  w_dark;
  logic [6:0]            w_seg_h;
  logic                  w_dp_h;
  logic [NUM_DIGITS-1:0] w_an_h;

  function automatic logic [6:0] f_decode(input logic [3:0] v);
    case (v)
      4'h0: f_decode = 7'h3F;
      4'h1: f_decode = 7'h06;
      4'h2: f_decode = 7'h5B;
      4'h3: f_decode = 7'h4F;
      4'h4: f_decode = 7'h66;
      4'h5: f_decode = 7'h6D;
      4'h6: f_decode = 7'h7D;
      4'h7: f_decode = 7'h07;
      4'h8: f_decode = 7'h7F;
      4'h9: f_decode = 7'h6F;
      4'hA: f_decode = 7'h77;
      4'hB: f_decode = 7'h7C;
      4'hC: f_decode = 7'h39;
      4'hD: f_decode = 7'h5E;
      4'hE: f_decode = 7'h7B;
      default: f_decode = 7'h71;
    endcase
  endfunction

  // Frame commit is the first cycle of slot 0; outputs of that cycle already use the committed data.
  assign w_commit = (r_cnt == '0) && (r_idx == '0);

  always_comb begin
    w_val = r_disp_val;
    w_dpv = r_disp_dp;
    w_blk = r_disp_blank;
    if (w_commit) begin
      if (bus.load) begin
        w_val = bus.din;
        w_dpv = bus.dp_in;
        w_blk = bus.blank;
      end else begin
        w_val = r_shd_val;
        w_dpv = r_shd_dp;
        w_blk = r_shd_blank;
      end
    end
  end

  // Digit is leading-zero when it and every more-significant digit are zero.
  assign w_upper = w_val >> {r_idx, 2'b00};
  assign w_digit = w_upper[3:0];
  assign w_dark  = w_blk[r_idx] || ((LZ_SUPPRESS != 0) && (r_idx != '0) && (w_upper == '0));
  assign w_seg_h = w_dark ? 7'h00 : f_decode(w_digit);
  assign w_dp_h  = !w_dark && w_dpv[r_idx];
  assign w_an_h  = (int'({1'b0, r_cnt}) >= BLANK_CYC) ? (NUM_DIGITS'(1) << r_idx) : '0;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt         <= '0;
      r_idx         <= '0;
      r_shd_val     <= '0;
      r_shd_dp      <= '0;
      r_shd_blank   <= '0;
      r_disp_val    <= '0;
      r_disp_dp     <= '0;
      r_disp_blank  <= '0;
      r_seg         <= {7{INV}};
      r_dp          <= INV;
      r_an          <= {NUM_DIGITS{INV}};
      r_frame_start <= 1'b0;
    end else begin
      if (bus.load) begin
        r_shd_val   <= bus.din;
        r_shd_dp    <= bus.dp_in;
        r_shd_blank <= bus.blank;
      end
      if (w_commit) begin
        r_disp_val   <= w_val;
        r_disp_dp    <= w_dpv;
        r_disp_blank <= w_blk;
      end
      if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_seg         <= w_seg_h ^ {7{INV}};
      r_dp          <= w_dp_h ^ INV;
      r_an          <= w_an_h ^ {NUM_DIGITS{INV}};
      r_frame_start <= w_commit;
    end
  end

  assign bus.seg         = r_seg;
  assign bus.dp          = r_dp;
  assign bus.an          = r_an;
  assign bus.frame_start = r_frame_start;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: two configurations share one stimulus stream and are
// checked every cycle against a time-indexed model, plus literal display expectations.
module tb_seg_scan_driver;
  localparam int N    = 4;
  localparam int RD_A = 4;
  localparam int RD_B = 5;
  localparam int BC_A = 1;
  localparam int BC_B = 0;
  localparam int AL_A = 1;
  localparam int AL_B = 0;
  localparam int LZ_A = 1;
  localparam int LZ_B = 0;
  localparam int P_RD [2] = '{RD_A, RD_B};
  localparam int P_BC [2] = '{BC_A, BC_B};
  localparam int P_AL [2] = '{AL_A, AL_B};
  localparam int P_LZ [2] = '{LZ_A, LZ_B};
  localparam logic [6:0] SEGTBL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h7B, 7'h71};
  localparam logic [3:0] PAT [16] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD,
                                      4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7};
  localparam logic [15:0] SW_V [4] = '{16'h0123, 16'h7654, 16'hBA98, 16'hFEDC};
  localparam logic [6:0] SW_E [4][4] = '{'{7'h4F, 7'h5B, 7'h06, 7'h3F},
                                         '{7'h66, 7'h6D, 7'h7D, 7'h07},
                                         '{7'h7F, 7'h6F, 7'h77, 7'h7C},
                                         '{7'h39, 7'h5E, 7'h7B, 7'h71}};

  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] tb_din;
  logic [3:0]  tb_dp;
  logic [3:0]  tb_blank;
  logic        tb_load;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  seg_scan_driver_if #(.NUM_DIGITS(N)) if_a ();
  seg_scan_driver_if #(.NUM_DIGITS(N)) if_b ();

  assign if_a.din   = tb_din;
  assign if_a.dp_in = tb_dp;
  assign if_a.blank = tb_blank;
  assign if_a.load  = tb_load;
  assign if_b.din   = tb_din;
  assign if_b.dp_in = tb_dp;
  assign if_b.blank = tb_blank;
  assign if_b.load  = tb_load;

  seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD_A), .BLANK_CYC(BC_A),
                    .ACTIVE_LOW(AL_A), .LZ_SUPPRESS(LZ_A)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if_a));

  seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD_B), .BLANK_CYC(BC_B),
                    .ACTIVE_LOW(AL_B), .LZ_SUPPRESS(LZ_B)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if_b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: output at each edge follows from the position in the frame since reset release.
  int          t_m [2];
  int          p_last [2];
  bit          valid [2];
  logic [15:0] shd_v [2];
  logic [3:0]  shd_d [2];
  logic [3:0]  shd_b [2];
  logic [15:0] disp_v [2];
  logic [3:0]  disp_d [2];
  logic [3:0]  disp_b [2];
  logic [6:0]  e_seg [2];
  logic        e_dp [2];
  logic [3:0]  e_an [2];
  logic        e_fs [2];
  int          m_p, m_slot, m_c, m_up;
  logic        m_dark, m_dph;
  logic [6:0]  m_sh;
  logic [3:0]  m_anh;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        valid[d]  = 1'b1;
        t_m[d]    = 0;
        p_last[d] = -1;
        shd_v[d]  = '0; shd_d[d] = '0; shd_b[d] = '0;
        disp_v[d] = '0; disp_d[d] = '0; disp_b[d] = '0;
        e_seg[d]  = (P_AL[d] != 0) ? 7'h7F : 7'h00;
        e_dp[d]   = (P_AL[d] != 0);
        e_an[d]   = (P_AL[d] != 0) ? 4'hF : 4'h0;
        e_fs[d]   = 1'b0;
      end else if (valid[d]) begin
        m_p = t_m[d] % (N * P_RD[d]);
        if (m_p == 0) begin
          if (tb_load) begin
            disp_v[d] = tb_din; disp_d[d] = tb_dp; disp_b[d] = tb_blank;
          end else begin
            disp_v[d] = shd_v[d]; disp_d[d] = shd_d[d]; disp_b[d] = shd_b[d];
          end
        end
        m_slot = m_p / P_RD[d];
        m_c    = m_p % P_RD[d];
        m_up   = int'(disp_v[d]) >> (4 * m_slot);
        m_dark = disp_b[d][m_slot] || ((P_LZ[d] != 0) && (m_slot > 0) && (m_up == 0));
        m_sh   = m_dark ? 7'h00 : SEGTBL[m_up & 15];
        m_dph  = !m_dark && disp_d[d][m_slot];
        m_anh  = (m_c >= P_BC[d]) ? 4'(1 << m_slot) : 4'h0;
        e_seg[d] = (P_AL[d] != 0) ? ~m_sh : m_sh;
        e_dp[d]  = (P_AL[d] != 0) ? ~m_dph : m_dph;
        e_an[d]  = (P_AL[d] != 0) ? ~m_anh : m_anh;
        e_fs[d]  = (m_p == 0);
        if (tb_load) begin
          shd_v[d] = tb_din; shd_d[d] = tb_dp; shd_b[d] = tb_blank;
        end
        t_m[d]++;
        p_last[d] = m_p;
      end
    end
    #1;
    if (valid[0]) begin
      chk("model seg_a", 32'(if_a.seg), 32'(e_seg[0]));
      chk("model dp_a", 32'(if_a.dp), 32'(e_dp[0]));
      chk("model an_a", 32'(if_a.an), 32'(e_an[0]));
      chk("model fs_a", 32'(if_a.frame_start), 32'(e_fs[0]));
    end
    if (valid[1]) begin
      chk("model seg_b", 32'(if_b.seg), 32'(e_seg[1]));
      chk("model dp_b", 32'(if_b.dp), 32'(e_dp[1]));
      chk("model an_b", 32'(if_b.an), 32'(e_an[1]));
      chk("model fs_b", 32'(if_b.frame_start), 32'(e_fs[1]));
    end
  end

  task automatic wait_pos(input int d, input int pos);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      if (p_last[d] == pos) return;
    end
    total++;
    bad++;
    $display("FAIL wait_pos dut%0d: frame position %0d not reached", d, pos);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dpv, input logic [3:0] bl);
    @(negedge clk);
    tb_din = v; tb_dp = dpv; tb_blank = bl; tb_load = 1'b1;
    @(negedge clk);
    tb_load = 1'b0;
  endtask

  function automatic logic [15:0] rnd_din();
    logic [15:0] v;
    for (int k = 0; k < 4; k++)
      v[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; tb_din = '0; tb_dp = '0; tb_blank = '0; tb_load = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset seg_a", 32'(if_a.seg), 32'h7F);
    chk("reset dp_a", 32'(if_a.dp), 32'h1);
    chk("reset an_a", 32'(if_a.an), 32'hF);
    chk("reset fs_a", 32'(if_a.frame_start), 32'h0);
    chk("reset seg_b", 32'(if_b.seg), 32'h00);
    chk("reset an_b", 32'(if_b.an), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(posedge clk);
      #2;
      chk("scan an_a", 32'(if_a.an), 32'(PAT[i % 16]));
      chk("scan fs_a", 32'(if_a.frame_start), 32'((i % 16) == 0));
    end

    for (int j = 0; j < 4; j++) begin
      do_load(SW_V[j], 4'h0, 4'h0);
      wait_pos(1, 0);
      for (int s = 0; s < 4; s++) begin
        wait_pos(1, s * RD_B + 2);
        chk("decode seg_b", 32'(if_b.seg), 32'(SW_E[j][s]));
      end
    end

    do_load(16'h1234, 4'h0, 4'h0);
    wait_pos(0, 0);
    wait_pos(0, 2);
    chk("sync old d0", 32'(if_a.seg), 32'h19);
    wait_pos(0, 5);
    do_load(16'h5678, 4'h0, 4'h0);
    wait_pos(0, 7);
    chk("sync old d1", 32'(if_a.seg), 32'h30);
    wait_pos(0, 10);
    chk("sync old d2", 32'(if_a.seg), 32'h24);
    wait_pos(0, 14);
    chk("sync old d3", 32'(if_a.seg), 32'h79);
    wait_pos(0, 0);
    chk("sync fs", 32'(if_a.frame_start), 32'h1);
    wait_pos(0, 2);
    chk("sync new d0", 32'(if_a.seg), 32'h00);
    wait_pos(0, 6);
    chk("sync new d1", 32'(if_a.seg), 32'h78);
    wait_pos(0, 10);
    chk("sync new d2", 32'(if_a.seg), 32'h02);
    wait_pos(0, 14);
    chk("sync new d3", 32'(if_a.seg), 32'h12);

    do_load(16'h0040, 4'h0, 4'h0);
    wait_pos(0, 0);
    wait_pos(0, 2);
    chk("lz d0", 32'(if_a.seg), 32'h40);
    wait_pos(0, 6);
    chk("lz d1", 32'(if_a.seg), 32'h19);
    wait_pos(0, 10);
    chk("lz d2 dark", 32'(if_a.seg), 32'h7F);
    wait_pos(0, 14);
    chk("lz d3 dark", 32'(if_a.seg), 32'h7F);
    chk("lz d3 an", 32'(if_a.an), 32'h7);
    wait_pos(1, 0);
    wait_pos(1, 7);
    chk("nolz d1", 32'(if_b.seg), 32'h66);
    wait_pos(1, 17);
    chk("nolz d3", 32'(if_b.seg), 32'h3F);

    do_load(16'h0040, 4'h0, 4'b0010);
    wait_pos(0, 0);
    wait_pos(0, 6);
    chk("blank d1 seg", 32'(if_a.seg), 32'h7F);
    chk("blank d1 an", 32'(if_a.an), 32'hD);

    do_load(16'h0040, 4'b0001, 4'b0010);
    wait_pos(0, 0);
    for (int s = 0; s < 4; s++) begin
      wait_pos(0, s * RD_A + 2);
      chk("dp slot", 32'(if_a.dp), 32'(s != 0));
    end

    wait_pos(0, N * RD_A - 1);
    do_load(16'hBEEF, 4'h0, 4'h0);
    wait_pos(0, 2);
    chk("bypass d0", 32'(if_a.seg), 32'h0E);
    wait_pos(0, 14);
    chk("bypass d3", 32'(if_a.seg), 32'h03);

    wait_pos(0, 9);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    chk("midrst seg_a", 32'(if_a.seg), 32'h7F);
    chk("midrst an_a", 32'(if_a.an), 32'hF);
    chk("midrst fs_a", 32'(if_a.frame_start), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #2;
      chk("restart an_a", 32'(if_a.an), 32'(PAT[i]));
      if (i == 2) chk("restart zeros", 32'(if_a.seg), 32'h40);
    end

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tb_din = 16'h00A5; tb_dp = 4'h0; tb_blank = 4'h0; tb_load = 1'b1;
    @(negedge clk);
    tb_load = 1'b0;
    wait_pos(0, 2);
    chk("release load d0", 32'(if_a.seg), 32'h12);
    wait_pos(0, 6);
    chk("release load d1", 32'(if_a.seg), 32'h08);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        tb_din   = rnd_din();
        tb_dp    = 4'($urandom_range(0, 15));
        tb_blank = 4'($urandom & $urandom);
        tb_load  = 1'b1;
      end else begin
        tb_load = 1'b0;
      end
      rst_n = ($urandom_range(0, 499) != 0);
    end
    @(negedge clk);
    tb_load = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #3;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
